// File: rtl/pcecd_pkg.sv
// Shared definitions for the PC Engine CD SCSI target engine:
// bus phase codes, status bytes and command-group lengths.
package pcecd_pkg;

  typedef enum logic [2:0] {
    BUS_FREE   = 3'd0,
    COMMAND    = 3'd1,
    DATA_IN    = 3'd2,
    STATUS     = 3'd3,
    MESSAGE_IN = 3'd4
  } phase_e;

  localparam logic [7:0] STATUS_GOOD  = 8'h00;
  localparam logic [7:0] STATUS_CHECK = 8'h02;

  localparam logic [3:0] CMD_LEN_G0 = 4'd6;
  localparam logic [3:0] CMD_LEN_G1 = 4'd10;

  // Group 0 opcodes are 6-byte CDBs, all others are 10 bytes.
  function automatic logic [3:0] cmd_len_f(
    input logic [2:0] grp
  );
    return (grp == 3'd0) ? CMD_LEN_G0 : CMD_LEN_G1;
  endfunction

endpackage

// File: rtl/pcecd_byte_fifo.sv
// DATA_IN byte buffer: push/pop/flush with full/empty and
// a drain flag for the pop that leaves the buffer empty.
module pcecd_byte_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = $clog2(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              drain_o
);

  localparam logic [FIFO_AW:0] DEPTH_C = FIFO_DEPTH[FIFO_AW:0];
  localparam logic [FIFO_AW:0] ONE_C   = {{FIFO_AW{1'b0}}, 1'b1};

  logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_q, wr_d;
  logic [FIFO_AW-1:0] rd_q, rd_d;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  logic               push_ok, pop_ok;

  assign full_o  = (cnt_q == DEPTH_C);
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign drain_o = pop_ok & ~push_ok
                 & (cnt_q == ONE_C);
  assign head_o  = mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_ok) wr_d = wr_q + 1'b1;
      if (pop_ok)  rd_d = rd_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + ONE_C;
        2'b01:   cnt_d = cnt_q - ONE_C;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/pcecd_scsi_target.sv
// CD-drive side SCSI bus-phase engine with REQ/ACK handshakes.
// Define PCECD_SCSI_INSYNC_EN to 2-flop synchronise sel/ack/rst.
module pcecd_scsi_target
  import pcecd_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int CMD_MAX    = 10,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = $clog2(FIFO_DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_sel,
  input  logic                      bus_ack,
  input  logic                      bus_rst,
  input  logic [DATA_W-1:0]         db_in,
  output logic [DATA_W-1:0]         db_out,
  output logic                      bsy,
  output logic                      req,
  output logic                      msg,
  output logic                      cd,
  output logic                      io,
  output logic                      cmd_valid,
  output logic [CMD_MAX*DATA_W-1:0] cmd_bytes,
  output logic [3:0]                cmd_len,
  input  logic                      data_push,
  input  logic [DATA_W-1:0]         data_wdata,
  output logic                      data_full,
  input  logic                      xfer_done,
  input  logic [DATA_W-1:0]         status_byte,
  input  logic [DATA_W-1:0]         msg_byte,
  output logic                      irq_data_ready,
  output logic                      irq_done,
  output logic [2:0]                phase
);

  logic sel_s, ack_s, rst_s;

`ifdef PCECD_SCSI_INSYNC_EN
  logic [2:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {bus_rst, bus_ack, bus_sel};
      sync2_q <= sync1_q;
    end
  end

  assign {rst_s, ack_s, sel_s} = sync2_q;
`else
  assign {rst_s, ack_s, sel_s} = {bus_rst, bus_ack, bus_sel};
`endif

  phase_e                    phase_q, phase_d;
  logic                      req_q, req_d;
  logic [3:0]                idx_q, idx_d;
  logic [3:0]                len_q, len_d;
  logic [3:0]                len_now;
  logic [CMD_MAX*DATA_W-1:0] cmd_q, cmd_d;
  logic                      last_q, last_d;
  logic                      cmdv_q, cmdv_d;
  logic                      pend_q, pend_d;
  logic                      sent_q, sent_d;
  logic [DATA_W-1:0]         stat_q, stat_d;
  logic [DATA_W-1:0]         msgb_q, msgb_d;
  logic                      irq_rdy_q, irq_rdy_d;
  logic                      irq_done_q, irq_done_d;
  logic                      hs, pop, flush;
  logic [DATA_W-1:0]         fifo_head;
  logic                      fifo_empty, fifo_drain;

  assign hs = req_q & ack_s;

  pcecd_byte_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .FIFO_AW    (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .flush_i (flush),
    .push_i  (data_push),
    .wdata_i (data_wdata),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .full_o  (data_full),
    .empty_o (fifo_empty),
    .drain_o (fifo_drain)
  );

  always_comb begin
    phase_d    = phase_q;
    req_d      = req_q;
    idx_d      = idx_q;
    len_d      = len_q;
    len_now    = len_q;
    cmd_d      = cmd_q;
    last_d     = last_q;
    cmdv_d     = 1'b0;
    pend_d     = pend_q;
    sent_d     = sent_q;
    stat_d     = stat_q;
    msgb_d     = msgb_q;
    irq_rdy_d  = 1'b0;
    irq_done_d = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;
    if (rst_s) begin
      phase_d = BUS_FREE;
      req_d   = 1'b0;
      idx_d   = '0;
      last_d  = 1'b0;
      pend_d  = 1'b0;
      sent_d  = 1'b0;
      flush   = 1'b1;
    end else begin
      unique case (phase_q)
        BUS_FREE: begin
          if (sel_s) begin
            phase_d = COMMAND;
            req_d   = ~ack_s;
            idx_d   = '0;
            last_d  = 1'b0;
            pend_d  = 1'b0;
            sent_d  = 1'b0;
          end
        end
        COMMAND: begin
          if (hs) begin
            req_d = 1'b0;
            if (idx_q == '0) begin
              len_now = cmd_len_f(db_in[7:5]);
              len_d   = len_now;
            end
            for (int i = 0; i < CMD_MAX; i++) begin
              if (idx_q == 4'(i))
                cmd_d[i*DATA_W +: DATA_W] = db_in;
            end
            idx_d = idx_q + 4'd1;
            if (idx_d == len_now) last_d = 1'b1;
          end else if (last_q) begin
            last_d  = 1'b0;
            cmdv_d  = 1'b1;
            phase_d = DATA_IN;
          end else if (!req_q && !ack_s) begin
            req_d = 1'b1;
          end
        end
        DATA_IN: begin
          if (xfer_done) begin
            pend_d = 1'b1;
            stat_d = status_byte;
            msgb_d = msg_byte;
          end
          // Leave only once the last byte's REQ has dropped.
          if (hs) begin
            req_d     = 1'b0;
            pop       = 1'b1;
            irq_rdy_d = fifo_drain;
          end else if (!req_q && fifo_empty
                       && (pend_q || xfer_done)) begin
            phase_d = STATUS;
            pend_d  = 1'b0;
          end else if (!req_q && !ack_s && !fifo_empty) begin
            req_d = 1'b1;
          end
        end
        STATUS: begin
          if (hs) begin
            req_d   = 1'b0;
            sent_d  = 1'b0;
            phase_d = MESSAGE_IN;
          end else if (!req_q && !ack_s) begin
            req_d = 1'b1;
          end
        end
        MESSAGE_IN: begin
          if (hs) begin
            req_d  = 1'b0;
            sent_d = 1'b1;
          end else if (sent_q) begin
            if (!ack_s) begin
              phase_d    = BUS_FREE;
              sent_d     = 1'b0;
              irq_done_d = 1'b1;
            end
          end else if (!req_q && !ack_s) begin
            req_d = 1'b1;
          end
        end
        default: phase_d = BUS_FREE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q    <= BUS_FREE;
      req_q      <= 1'b0;
      idx_q      <= '0;
      len_q      <= '0;
      cmd_q      <= '0;
      last_q     <= 1'b0;
      cmdv_q     <= 1'b0;
      pend_q     <= 1'b0;
      sent_q     <= 1'b0;
      stat_q     <= DATA_W'(STATUS_GOOD);
      msgb_q     <= '0;
      irq_rdy_q  <= 1'b0;
      irq_done_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      req_q      <= req_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      cmd_q      <= cmd_d;
      last_q     <= last_d;
      cmdv_q     <= cmdv_d;
      pend_q     <= pend_d;
      sent_q     <= sent_d;
      stat_q     <= stat_d;
      msgb_q     <= msgb_d;
      irq_rdy_q  <= irq_rdy_d;
      irq_done_q <= irq_done_d;
    end
  end

  always_comb begin
    db_out = '0;
    unique case (phase_q)
      DATA_IN:    db_out = fifo_empty ? '0 : fifo_head;
      STATUS:     db_out = stat_q;
      MESSAGE_IN: db_out = msgb_q;
      default:    db_out = '0;
    endcase
  end

  assign bsy            = (phase_q != BUS_FREE);
  assign cd             = (phase_q == COMMAND)
                        | (phase_q == STATUS)
                        | (phase_q == MESSAGE_IN);
  assign io             = (phase_q == DATA_IN)
                        | (phase_q == STATUS)
                        | (phase_q == MESSAGE_IN);
  assign msg            = (phase_q == MESSAGE_IN);
  assign req            = req_q;
  assign cmd_valid      = cmdv_q;
  assign cmd_bytes      = cmd_q;
  assign cmd_len        = len_q;
  assign irq_data_ready = irq_rdy_q;
  assign irq_done       = irq_done_q;
  assign phase          = phase_q;

endmodule

// File: tb/tb_pcecd_scsi_target.sv
// Self-checking bench for pcecd_scsi_target: command table plus
// hand-written reset-abort, FIFO-full and held-ACK sequences.
module tb_pcecd_scsi_target;
  import pcecd_pkg::*;

  localparam int DATA_W     = 8;
  localparam int CMD_MAX    = 10;
  localparam int FIFO_DEPTH = 16;

  logic                      clk = 1'b0;
  logic                      reset = 1'b0;
  logic                      bus_sel = 1'b0;
  logic                      bus_ack = 1'b0;
  logic                      bus_rst = 1'b0;
  logic [DATA_W-1:0]         db_in = '0;
  logic [DATA_W-1:0]         db_out;
  logic                      bsy, req, msg, cd, io;
  logic                      cmd_valid;
  logic [CMD_MAX*DATA_W-1:0] cmd_bytes;
  logic [3:0]                cmd_len;
  logic                      data_push = 1'b0;
  logic [DATA_W-1:0]         data_wdata = '0;
  logic                      data_full;
  logic                      xfer_done = 1'b0;
  logic [DATA_W-1:0]         status_byte = '0;
  logic [DATA_W-1:0]         msg_byte = '0;
  logic                      irq_data_ready, irq_done;
  logic [2:0]                phase;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];

  typedef struct {
    logic [7:0] op;
    int         nb;
    logic [3:0] len;
    int         nd;
    logic [7:0] st;
    logic [7:0] mb;
  } vec_t;

  vec_t vecs[4];

  pcecd_scsi_target #(
    .DATA_W     (DATA_W),
    .CMD_MAX    (CMD_MAX),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bus_sel        (bus_sel),
    .bus_ack        (bus_ack),
    .bus_rst        (bus_rst),
    .db_in          (db_in),
    .db_out         (db_out),
    .bsy            (bsy),
    .req            (req),
    .msg            (msg),
    .cd             (cd),
    .io             (io),
    .cmd_valid      (cmd_valid),
    .cmd_bytes      (cmd_bytes),
    .cmd_len        (cmd_len),
    .data_push      (data_push),
    .data_wdata     (data_wdata),
    .data_full      (data_full),
    .xfer_done      (xfer_done),
    .status_byte    (status_byte),
    .msg_byte       (msg_byte),
    .irq_data_ready (irq_data_ready),
    .irq_done       (irq_done),
    .phase          (phase)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] cbyte(input int j, input int vi);
    return 8'(j * 17 + vi);
  endfunction

  task automatic wait_req(input string name);
    int n = 0;
    while (req !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_req"}, 64'(req), 64'd1);
  endtask

  task automatic select_chk();
    bus_sel = 1'b1;
    @(negedge clk);
    bus_sel = 1'b0;
    chk("sel_phase", 64'(phase), 64'(COMMAND));
    chk("sel_bsy_cd_req_io_msg",
        {bsy, cd, req, io, msg}, 64'b11100);
  endtask

  task automatic send_bytes(input logic [7:0] op, input int from,
                            input int nb, input int vi);
    for (int j = from; j < nb; j++) begin
      wait_req("cmd");
      db_in   = (j == 0) ? op : cbyte(j, vi);
      bus_ack = 1'b1;
      @(negedge clk);
      bus_ack = 1'b0;
      db_in   = '0;
    end
  endtask

  task automatic check_cmd(input logic [7:0] op, input int nb,
                           input logic [3:0] len, input int vi);
    chk("cmd_valid_early", 64'(cmd_valid), 64'd0);
    @(negedge clk);
    chk("cmd_valid", 64'(cmd_valid), 64'd1);
    chk("cmd_len", 64'(cmd_len), 64'(len));
    chk("cmd_byte0", 64'(cmd_bytes[7:0]), 64'(op));
    chk("cmd_last", 64'(cmd_bytes[(nb-1)*8 +: 8]),
        64'(cbyte(nb - 1, vi)));
    chk("din_phase", 64'(phase), 64'(DATA_IN));
    chk("din_ctl", {bsy, cd, io, msg}, 64'b1010);
    @(negedge clk);
    chk("cmd_valid_pulse", 64'(cmd_valid), 64'd0);
  endtask

  task automatic push_byte(input logic [7:0] b, input bit ok);
    data_push  = 1'b1;
    data_wdata = b;
    @(negedge clk);
    data_push  = 1'b0;
    if (ok) sb.push_back(b);
  endtask

  task automatic done(input logic [7:0] st, input logic [7:0] mb);
    status_byte = st;
    msg_byte    = mb;
    xfer_done   = 1'b1;
    @(negedge clk);
    xfer_done   = 1'b0;
    status_byte = 8'hEE;
    msg_byte    = 8'hEE;
    sb.push_back(st);
    sb.push_back(mb);
  endtask

  task automatic drain(input int nd);
    logic [7:0] e;
    logic [2:0] ep;
    for (int k = 0; k < nd + 2; k++) begin
      wait_req("drain");
      ep = (k < nd) ? DATA_IN : (k == nd) ? STATUS : MESSAGE_IN;
      chk("drain_phase", 64'(phase), 64'(ep));
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("db_out", 64'(db_out), 64'(e));
      end
      bus_ack = 1'b1;
      @(negedge clk);
      bus_ack = 1'b0;
      chk("req_drop", 64'(req), 64'd0);
      if (k < nd)
        chk("irq_data_ready", 64'(irq_data_ready),
            64'(k == nd - 1));
    end
    @(negedge clk);
    chk("irq_done", 64'(irq_done), 64'd1);
    chk("free_ctl", {bsy, req, cd, io, msg}, 64'd0);
    chk("free_phase", 64'(phase), 64'(BUS_FREE));
    @(negedge clk);
    chk("irq_done_pulse", 64'(irq_done), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    vecs[0] = '{8'h08, 6,  4'd6,  3, 8'h00, 8'h00};
    vecs[1] = '{8'hD8, 10, 4'd10, 0, 8'h02, 8'h00};
    vecs[2] = '{8'h28, 10, 4'd10, 5, 8'h00, 8'h80};
    vecs[3] = '{8'h12, 6,  4'd6,  1, 8'h02, 8'h07};

    repeat (2) @(negedge clk);
    chk("rst_phase", 64'(phase), 64'(BUS_FREE));
    chk("rst_ctl", {bsy, req, msg, cd, io}, 64'd0);
    chk("rst_db_out", 64'(db_out), 64'd0);
    chk("rst_cmd", {cmd_valid, cmd_len, data_full,
                    irq_data_ready, irq_done}, 64'd0);
    chk("rst_cmd_bytes", 64'(cmd_bytes == '0), 64'd1);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      select_chk();
      send_bytes(vecs[i].op, 0, vecs[i].nb, i);
      check_cmd(vecs[i].op, vecs[i].nb, vecs[i].len, i);
      for (int k = 0; k < vecs[i].nd; k++)
        push_byte(8'(8'hA1 + k + i * 16), 1'b1);
      done(vecs[i].st, vecs[i].mb);
      drain(vecs[i].nd);
    end

    // FIFO overflow: 17th push dropped
    select_chk();
    send_bytes(8'h08, 0, 6, 5);
    check_cmd(8'h08, 6, 4'd6, 5);
    for (int i = 0; i < 17; i++) begin
      push_byte(8'(8'h40 + i), i < FIFO_DEPTH);
      if (i == 14) chk("not_full", 64'(data_full), 64'd0);
      if (i >= 15) chk("full", 64'(data_full), 64'd1);
    end
    done(8'h00, 8'h00);
    drain(16);

    // Bus reset mid DATA_IN
    select_chk();
    send_bytes(8'h08, 0, 6, 6);
    check_cmd(8'h08, 6, 4'd6, 6);
    for (int k = 0; k < 5; k++) push_byte(8'(8'hC0 + k), 1'b1);
    done(8'h02, 8'h00);
    bus_sel = 1'b1;
    @(negedge clk);
    bus_sel = 1'b0;
    chk("sel_ignored", 64'(phase), 64'(DATA_IN));
    bus_rst = 1'b1;
    @(negedge clk);
    bus_rst = 1'b0;
    chk("rst_free", 64'(phase), 64'(BUS_FREE));
    chk("rst_ctl2", {bsy, req, cd, io, msg, data_full}, 64'd0);
    chk("rst_noirq", {irq_data_ready, irq_done}, 64'd0);
    @(negedge clk);
    chk("rst_noirq2", {irq_data_ready, irq_done}, 64'd0);
    sb.delete();
    select_chk();
    send_bytes(8'h08, 0, 6, 7);
    check_cmd(8'h08, 6, 4'd6, 7);
    done(8'h00, 8'h01);
    drain(0);

    // ACK held across the REQ drop
    select_chk();
    wait_req("hold");
    db_in   = 8'h08;
    bus_ack = 1'b1;
    @(negedge clk);
    db_in = '0;
    chk("hold_drop", 64'(req), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("hold_low", 64'(req), 64'd0);
    end
    bus_ack = 1'b0;
    @(negedge clk);
    chk("hold_rise", 64'(req), 64'd1);
    send_bytes(8'h08, 1, 6, 8);
    check_cmd(8'h08, 6, 4'd6, 8);
    done(8'h02, 8'h00);
    drain(0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
